// File: rtl/cpu_front_end_pkg.sv
// Shared LEGv8 front-end definitions: opcode patterns, branch condition codes
// and the ALU operation encoding used by the decoder.
package cpu_front_end_pkg;

  typedef enum logic [2:0] {
    ALU_PASS_B = 3'b000,
    ALU_ADD    = 3'b010,
    ALU_SUB    = 3'b011,
    ALU_AND    = 3'b100,
    ALU_OR     = 3'b101,
    ALU_XOR    = 3'b110
  } alu_op_t;

  // Opcode patterns, grouped by how many leading instruction bits they occupy.
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_EOR   = 11'b11001010000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [4:0]  COND_LT  = 5'b01011;

endpackage

// File: rtl/cpu_front_end_pc_reg.sv
// 64-bit program-counter register with load enable and asynchronous
// active-low clear.
module pc_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [63:0] d,
  output logic [63:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 64'h0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/cpu_front_end.sv
// LEGv8 front end: registered PC plus a purely combinational instruction
// decoder and immediate extenders. Reset only touches the PC.
module cpu_front_end
  import cpu_front_end_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        negative,
  input  logic        overflow,
  input  logic [63:0] pc_d,
  input  logic        pc_en,
  output logic [63:0] pc,
  output logic        Reg2Loc,
  output logic        ALUsrc,
  output logic        ALUsrc1,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemWri,
  output logic        Readmem,
  output logic        BrTaken,
  output logic        UncondBr,
  output logic [2:0]  ALUOp,
  output logic [63:0] DAddr9,
  output logic [63:0] CondAddr19,
  output logic [63:0] BrAddr26,
  output logic [63:0] Imm12
);

  alu_op_t alu_op;

  pc_reg u_pc_reg (
    .clk   (clk),
    .rst_n (reset),
    .en    (pc_en),
    .d     (pc_d),
    .q     (pc)
  );

  // Longest opcode patterns are tested first so a shorter pattern can never
  // shadow a more specific one.
  always_comb begin
    Reg2Loc  = 1'b0;
    ALUsrc   = 1'b0;
    ALUsrc1  = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemWri   = 1'b0;
    Readmem  = 1'b0;
    BrTaken  = 1'b0;
    UncondBr = 1'b0;
    alu_op   = ALU_PASS_B;
    if (instruction[31:21] == OP_ADDS) begin
      Reg2Loc  = 1'b1;
      RegWrite = 1'b1;
      alu_op   = ALU_ADD;
    end else if (instruction[31:21] == OP_SUBS) begin
      Reg2Loc  = 1'b1;
      RegWrite = 1'b1;
      alu_op   = ALU_SUB;
    end else if (instruction[31:21] == OP_AND) begin
      Reg2Loc  = 1'b1;
      RegWrite = 1'b1;
      alu_op   = ALU_AND;
    end else if (instruction[31:21] == OP_EOR) begin
      Reg2Loc  = 1'b1;
      RegWrite = 1'b1;
      alu_op   = ALU_XOR;
    end else if (instruction[31:21] == OP_LDUR) begin
      ALUsrc   = 1'b1;
      MemtoReg = 1'b1;
      RegWrite = 1'b1;
      Readmem  = 1'b1;
      alu_op   = ALU_ADD;
    end else if (instruction[31:21] == OP_STUR) begin
      ALUsrc   = 1'b1;
      MemWri   = 1'b1;
      alu_op   = ALU_ADD;
    end else if (instruction[31:22] == OP_ADDI) begin
      ALUsrc   = 1'b1;
      ALUsrc1  = 1'b1;
      RegWrite = 1'b1;
      Reg2Loc  = 1'b1;
      alu_op   = ALU_ADD;
    end else if (instruction[31:24] == OP_CBZ) begin
      BrTaken  = zero;
    end else if ((instruction[31:24] == OP_BCOND) && (instruction[4:0] == COND_LT)) begin
      BrTaken  = negative ^ overflow;
    end else if (instruction[31:26] == OP_B) begin
      BrTaken  = 1'b1;
      UncondBr = 1'b1;
    end
  end

  assign ALUOp      = alu_op;
  assign DAddr9     = {{55{instruction[20]}}, instruction[20:12]};
  assign CondAddr19 = {{45{instruction[23]}}, instruction[23:5]};
  assign BrAddr26   = {{38{instruction[25]}}, instruction[25:0]};
  assign Imm12      = {52'h0, instruction[21:10]};

endmodule

// File: tb/tb_cpu_front_end.sv
// Scoreboard bench for cpu_front_end: PC load/hold/reset sequencing and
// directed decode vectors with hand-derived control words.
module tb_cpu_front_end;

  localparam int W = 12 + 4 * 64;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic        zero, negative, overflow;
  logic [63:0] pc_d;
  logic        pc_en;
  logic [63:0] pc;
  logic        Reg2Loc, ALUsrc, ALUsrc1, MemtoReg, RegWrite, MemWri, Readmem;
  logic        BrTaken, UncondBr;
  logic [2:0]  ALUOp;
  logic [63:0] DAddr9, CondAddr19, BrAddr26, Imm12;

  logic [W-1:0]  exp_q[$];
  logic [63:0]   pc_q[$];
  logic [31:0]   name_q[$];
  logic          dec_valid;
  logic          pc_valid;
  int            tests;
  int            fails;

  cpu_front_end dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .zero        (zero),
    .negative    (negative),
    .overflow    (overflow),
    .pc_d        (pc_d),
    .pc_en       (pc_en),
    .pc          (pc),
    .Reg2Loc     (Reg2Loc),
    .ALUsrc      (ALUsrc),
    .ALUsrc1     (ALUsrc1),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .MemWri      (MemWri),
    .Readmem     (Readmem),
    .BrTaken     (BrTaken),
    .UncondBr    (UncondBr),
    .ALUOp       (ALUOp),
    .DAddr9      (DAddr9),
    .CondAddr19  (CondAddr19),
    .BrAddr26    (BrAddr26),
    .Imm12       (Imm12)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Reference extension: subtract 2^w when the field's top bit is set.
  function automatic logic [63:0] field(input logic [31:0] ins, input int lo, input int w,
                                        input bit signed_ext);
    logic [63:0] v;
    v = ({32'h0, ins} >> lo) & ((64'd1 << w) - 64'd1);
    if (signed_ext && v[w-1]) v = v - (64'd1 << w);
    return v;
  endfunction

  // Driver tasks
  task automatic check_pc(input logic [63:0] exp_pc);
    pc_q.push_back(exp_pc);
    pc_valid = 1'b1;
    @(negedge clk);
    #1 pc_valid = 1'b0;
  endtask

  // ctrl = {Reg2Loc,ALUsrc,ALUsrc1,MemtoReg,RegWrite,MemWri,Readmem,BrTaken,UncondBr,ALUOp}
  task automatic apply(input logic [31:0] ins, input logic z, input logic n, input logic v,
                       input logic [11:0] ctrl, input logic [31:0] tag);
    instruction = ins;
    zero        = z;
    negative    = n;
    overflow    = v;
    exp_q.push_back({ctrl, field(ins, 12, 9, 1'b1), field(ins, 5, 19, 1'b1),
                     field(ins, 0, 26, 1'b1), field(ins, 10, 12, 1'b0)});
    name_q.push_back(tag);
    dec_valid = 1'b1;
    @(negedge clk);
    #1 dec_valid = 1'b0;
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (pc_valid) begin
      tests++;
      if (pc_q.size() == 0) begin
        fails++;
        $display("FAIL pc: sample with empty expected queue, got %h", pc);
      end else begin
        logic [63:0] e;
        e = pc_q.pop_front();
        if (pc !== e) begin
          fails++;
          $display("FAIL pc: got %h expected %h", pc, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (dec_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL decode: sample with empty expected queue");
      end else begin
        logic [W-1:0] e;
        logic [11:0]  got_ctrl;
        logic [31:0]  tag;
        e   = exp_q.pop_front();
        tag = name_q.pop_front();
        got_ctrl = {Reg2Loc, ALUsrc, ALUsrc1, MemtoReg, RegWrite, MemWri, Readmem,
                    BrTaken, UncondBr, ALUOp};
        tests += 5;
        if (got_ctrl !== e[W-1 -: 12]) begin
          fails++;
          $display("FAIL ctrl %s: got %b expected %b", tag, got_ctrl, e[W-1 -: 12]);
        end
        if (DAddr9 !== e[255:192]) begin
          fails++;
          $display("FAIL DAddr9 %s: got %h expected %h", tag, DAddr9, e[255:192]);
        end
        if (CondAddr19 !== e[191:128]) begin
          fails++;
          $display("FAIL CondAddr19 %s: got %h expected %h", tag, CondAddr19, e[191:128]);
        end
        if (BrAddr26 !== e[127:64]) begin
          fails++;
          $display("FAIL BrAddr26 %s: got %h expected %h", tag, BrAddr26, e[127:64]);
        end
        if (Imm12 !== e[63:0]) begin
          fails++;
          $display("FAIL Imm12 %s: got %h expected %h", tag, Imm12, e[63:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    tests = 0;
    fails = 0;
    dec_valid = 1'b0;
    pc_valid  = 1'b0;
    reset = 1'b0;
    pc_en = 1'b1;
    pc_d  = 64'h123;
    instruction = 32'h0;
    zero = 1'b0; negative = 1'b0; overflow = 1'b0;

    // pc stays 0 under reset even with pc_en high
    repeat (2) @(posedge clk);
    check_pc(64'h0);

    // decode is live while reset is asserted
    apply(32'h91001401, 1'b0, 1'b0, 1'b0, {9'b111010000, 3'b010}, "ADDIr");

    reset = 1'b1;
    pc_en = 1'b1;
    pc_d  = 64'h40;
    check_pc(64'h40);
    pc_en = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    check_pc(64'h0);
    reset = 1'b1;
    pc_en = 1'b1;
    pc_d  = 64'h4;
    check_pc(64'h4);
    pc_en = 1'b0;
    pc_d  = 64'h8;
    check_pc(64'h4);
    check_pc(64'h4);

    apply(32'h91001401, 1'b0, 1'b0, 1'b0, {9'b111010000, 3'b010}, "ADDI");
    apply(32'h91001401, 1'b1, 1'b1, 1'b0, {9'b111010000, 3'b010}, "ADDIf");
    apply(32'hAB020020, 1'b1, 1'b0, 1'b0, {9'b100010000, 3'b010}, "ADDS");
    apply(32'hEB030041, 1'b0, 1'b1, 1'b1, {9'b100010000, 3'b011}, "SUBS");
    apply(32'h8A020020, 1'b0, 1'b0, 1'b0, {9'b100010000, 3'b100}, "AND");
    apply(32'hCA020020, 1'b0, 1'b0, 1'b0, {9'b100010000, 3'b110}, "EOR");
    apply(32'hF85F8022, 1'b0, 1'b0, 1'b0, {9'b010110100, 3'b010}, "LDUR");
    apply(32'hF81F8022, 1'b0, 1'b0, 1'b0, {9'b010001000, 3'b010}, "STUR");
    apply(32'hB4000040, 1'b1, 1'b0, 1'b0, {9'b000000010, 3'b000}, "CBZ1");
    apply(32'hB4000040, 1'b0, 1'b1, 1'b1, {9'b000000000, 3'b000}, "CBZ0");
    apply(32'h17FFFFFF, 1'b0, 1'b0, 1'b0, {9'b000000011, 3'b000}, "B");
    apply(32'h5400000B, 1'b0, 1'b1, 1'b0, {9'b000000010, 3'b000}, "BLT10");
    apply(32'h5400000B, 1'b0, 1'b1, 1'b1, {9'b000000000, 3'b000}, "BLT11");
    apply(32'h5400000B, 1'b1, 1'b0, 1'b1, {9'b000000010, 3'b000}, "BLT01");
    apply(32'h5400000B, 1'b1, 1'b0, 1'b0, {9'b000000000, 3'b000}, "BLT00");
    apply(32'h5400000A, 1'b1, 1'b1, 1'b0, {9'b000000000, 3'b000}, "BCND");
    apply(32'h00000000, 1'b1, 1'b1, 1'b1, {9'b000000000, 3'b000}, "ZERO");

    // spot checks of the extenders against literal values
    instruction = 32'hF85F8022;
    #1;
    tests++;
    if (DAddr9 !== 64'hFFFFFFFFFFFFFFF8) begin
      fails++;
      $display("FAIL DAddr9 literal: got %h expected %h", DAddr9, 64'hFFFFFFFFFFFFFFF8);
    end
    instruction = 32'h17FFFFFF;
    #1;
    tests++;
    if (BrAddr26 !== 64'hFFFFFFFFFFFFFFFF) begin
      fails++;
      $display("FAIL BrAddr26 literal: got %h expected %h", BrAddr26, 64'hFFFFFFFFFFFFFFFF);
    end
    instruction = 32'h91001401;
    #1;
    tests++;
    if (Imm12 !== 64'd5) begin
      fails++;
      $display("FAIL Imm12 literal: got %h expected %h", Imm12, 64'd5);
    end
    instruction = 32'hB4000040;
    #1;
    tests++;
    if (CondAddr19 !== 64'd2) begin
      fails++;
      $display("FAIL CondAddr19 literal: got %h expected %h", CondAddr19, 64'd2);
    end

    repeat (2) @(posedge clk);
    tests++;
    if ((exp_q.size() + pc_q.size()) != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, expected 0",
               exp_q.size() + pc_q.size());
    end

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
